bpred_ctrl: RTL and testbench

BPRED_CTRL -- requirements
Module: bpred_ctrl

---
 rtl/bpred_pkg.sv | 30 +++
 rtl/bht_table.sv | 41 ++++
 rtl/bpred_ctrl.sv | 113 +++++++++++
 tb/tb_bpred_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared branch-predictor types: BHT counter states, controller FSM states,
// the pipeline NOP encoding and the saturating counter update.
package bpred_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_state_e;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } fsm_state_e;

  localparam logic [19:0] NOP_INSTR = 20'hF0000;

  function automatic bht_state_e sat_update(input bht_state_e cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken && (cur != ST)) begin
      nxt = cur + 2'd1;
    end else if (!taken && (cur != SNT)) begin
      nxt = cur - 2'd1;
    end
    return bht_state_e'(nxt);
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: 2**IDX two-bit saturating counters, one combinational
// read port and one synchronous saturating-update write port.
module bht_table
  import bpred_pkg::*;
#(
  parameter int IDX = 4
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic [IDX-1:0] rd_idx,
  output bht_state_e     rd_state,
  input  logic           wr_en,
  input  logic [IDX-1:0] wr_idx,
  input  logic           wr_taken
);

  localparam int DEPTH = 2 ** IDX;

  bht_state_e entries_q [DEPTH];
  bht_state_e entries_d [DEPTH];

  // Reads come from the flops, so a same-cycle update at the same index is
  // seen by fetch only on the following cycle.
  assign rd_state = entries_q[rd_idx];

  always_comb begin
    entries_d = entries_q;
    if (wr_en) begin
      entries_d[wr_idx] = sat_update(entries_q[wr_idx], wr_taken);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      entries_q <= '{default: WNT};
    end else begin
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/bpred_ctrl.sv
// Branch prediction controller: BHT lookup for fetch, resolve-driven training,
// mispredict flush with a fixed-length recovery window, saturating statistics.
module bpred_ctrl
  import bpred_pkg::*;
#(
  parameter int Psize       = 5,
  parameter int IDX         = 4,
  parameter int RECOVER_CYC = 1,
  parameter int STAT_W      = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [Psize-1:0]  fetch_pc,
  input  logic              fetch_is_branch,
  input  logic              resolve_valid,
  input  logic [Psize-1:0]  resolve_pc,
  input  logic              resolve_taken,
  input  logic              resolve_pred,
  output logic              take_branch,
  output logic              mispredict,
  output logic              recovering,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int              RCW       = 3;
  localparam logic [RCW-1:0]  RCNT_LOAD = RCW'(RECOVER_CYC - 1);

  bht_state_e        fetch_state;
  logic              accepted;
  fsm_state_e        state_q, state_d;
  logic [RCW-1:0]    rcnt_q, rcnt_d;
  logic              recovering_q, recovering_d;
  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  bht_table #(.IDX(IDX)) u_bht (
    .clk      (clk),
    .nreset   (nreset),
    .rd_idx   (fetch_pc[IDX-1:0]),
    .rd_state (fetch_state),
    .wr_en    (accepted),
    .wr_idx   (resolve_pc[IDX-1:0]),
    .wr_taken (resolve_taken)
  );

  // Gating with nreset keeps both outputs quiet for the whole reset window.
  always_comb begin
    accepted    = nreset && resolve_valid && (state_q == IDLE);
    mispredict  = accepted && (resolve_taken != resolve_pred);
    take_branch = nreset && fetch_is_branch && fetch_state[1];
  end

  always_comb begin
    state_d       = state_q;
    rcnt_d        = rcnt_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d = RECOVER;
          rcnt_d  = RCNT_LOAD;
        end
      end
      RECOVER: begin
        if (rcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    recovering_d = (state_d == RECOVER);
    // mispredict implies accepted, so mispred_cnt can never pass branch_cnt.
    if (accepted && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
    end
    if (mispredict && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= IDLE;
      rcnt_q        <= '0;
      recovering_q  <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      rcnt_q        <= rcnt_d;
      recovering_q  <= recovering_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign recovering  = recovering_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  logic unused_nop;
  assign unused_nop = ^NOP_INSTR;

  if (Psize > IDX) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^{fetch_pc[Psize-1:IDX], resolve_pc[Psize-1:IDX]};
  end

endmodule

// File: tb/tb_bpred_ctrl.sv
// Scoreboard bench for bpred_ctrl: stimulus pushes expected output values,
// a negedge monitor pops and compares them.
module tb_bpred_ctrl;

  localparam int PS = 5;
  localparam int IX = 4;
  localparam int RC = 3;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          nreset;
  logic [PS-1:0] fetch_pc;
  logic          fetch_is_branch;
  logic          resolve_valid;
  logic [PS-1:0] resolve_pc;
  logic          resolve_taken;
  logic          resolve_pred;
  logic          take_branch;
  logic          mispredict;
  logic          recovering;
  logic [SW-1:0] branch_cnt;
  logic [SW-1:0] mispred_cnt;

  typedef enum {K_TB, K_MP, K_REC, K_BC, K_MC} kind_e;
  typedef struct {
    kind_e kind;
    int    val;
    string name;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  bpred_ctrl #(
    .Psize(PS), .IDX(IX), .RECOVER_CYC(RC), .STAT_W(SW)
  ) dut (
    .clk             (clk),
    .nreset          (nreset),
    .fetch_pc        (fetch_pc),
    .fetch_is_branch (fetch_is_branch),
    .resolve_valid   (resolve_valid),
    .resolve_pc      (resolve_pc),
    .resolve_taken   (resolve_taken),
    .resolve_pred    (resolve_pred),
    .take_branch     (take_branch),
    .mispredict      (mispredict),
    .recovering      (recovering),
    .branch_cnt      (branch_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic exp_out(input kind_e k, input int v, input string n);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = n;
    sbq.push_back(e);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int fpc, input logic br, input logic rv,
                       input int rpc, input logic tk, input logic pr);
    fetch_pc        = PS'(fpc);
    fetch_is_branch = br;
    resolve_valid   = rv;
    resolve_pc      = PS'(rpc);
    resolve_taken   = tk;
    resolve_pred    = pr;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        exp_t e;
        int   act;
        e = sbq.pop_front();
        case (e.kind)
          K_TB:    act = int'(take_branch);
          K_MP:    act = int'(mispredict);
          K_REC:   act = int'(recovering);
          K_BC:    act = int'(branch_cnt);
          default: act = int'(mispred_cnt);
        endcase
        checks++;
        if (act != e.val) begin
          failures++;
          $display("FAIL %s: got %0d expected %0d at %0t", e.name, act, e.val, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held: outputs must stay low even with a mispredicting resolve.
    nreset = 1'b0;
    drive(5, 1, 1, 5, 1, 0);
    #2;
    exp_out(K_TB, 0, "rst_take");
    exp_out(K_MP, 0, "rst_mispred");
    next_cyc();
    next_cyc();
    nreset = 1'b1;
    drive(5, 1, 0, 5, 0, 0);
    exp_out(K_TB,  0, "post_rst_take");
    exp_out(K_BC,  0, "post_rst_bc");
    exp_out(K_MC,  0, "post_rst_mc");
    exp_out(K_REC, 0, "post_rst_rec");

    // First resolve mispredicts: WNT -> WT, enter RECOVER.
    next_cyc();
    drive(5, 1, 1, 5, 1, 0);
    exp_out(K_MP,  1, "first_mispred");
    exp_out(K_TB,  0, "first_take");
    exp_out(K_REC, 0, "first_rec");

    // Resolves inside RECOVER would decrement entry 5 if not ignored.
    for (int i = 0; i < RC; i++) begin
      next_cyc();
      drive(5, 1, 1, 5, 0, 1);
      exp_out(K_REC, 1, "rec_window");
      exp_out(K_MP,  0, "rec_mp_forced");
      if (i == 0) begin
        exp_out(K_TB, 1, "wt_take");
        exp_out(K_BC, 1, "bc_one");
        exp_out(K_MC, 1, "mc_one");
      end
    end

    next_cyc();
    drive(5, 1, 1, 5, 1, 1);
    exp_out(K_REC, 0, "rec_exit");
    exp_out(K_MP,  0, "correct_mp");
    exp_out(K_TB,  1, "bht_untouched_in_rec");
    exp_out(K_BC,  1, "bc_untouched_in_rec");

    next_cyc();
    drive(5, 1, 1, 5, 1, 1);
    exp_out(K_BC, 2, "bc_two");
    exp_out(K_TB, 1, "st_take");
    exp_out(K_MP, 0, "correct_mp2");

    // Entry saturated at ST; one not-taken drops it to WT (still taken).
    next_cyc();
    drive(5, 1, 1, 5, 0, 1);
    exp_out(K_BC, 3, "bc_three");
    exp_out(K_MC, 1, "mc_still_one");
    exp_out(K_MP, 1, "second_mispred");

    next_cyc();
    drive(5, 1, 0, 5, 0, 0);
    exp_out(K_TB,  1, "sat_hold");
    exp_out(K_REC, 1, "rec2_c1");
    exp_out(K_MC,  2, "mc_two");
    exp_out(K_BC,  4, "bc_four");
    next_cyc();
    exp_out(K_REC, 1, "rec2_c2");
    next_cyc();
    exp_out(K_REC, 1, "rec2_c3");
    next_cyc();
    exp_out(K_REC, 0, "rec2_exit");

    // pc 21 aliases to index 5: fetch sees WT while update writes WNT.
    next_cyc();
    drive(21, 1, 1, 21, 0, 0);
    exp_out(K_TB, 1, "alias_old");
    exp_out(K_MP, 0, "alias_mp");
    next_cyc();
    drive(5, 1, 0, 5, 0, 0);
    exp_out(K_TB, 0, "alias_new");
    exp_out(K_BC, 5, "bc_five");

    // Fresh reset, then 300 correct resolves to saturate branch_cnt.
    next_cyc();
    nreset = 1'b0;
    next_cyc();
    nreset = 1'b1;
    for (int i = 0; i < 300; i++) begin
      next_cyc();
      drive(3, 1, 1, 3, i[0], i[0]);
      if (i == 100) exp_out(K_MP, 0, "sat_run_mp");
      if (i == 254) exp_out(K_BC, 254, "bc_254");
      if (i == 255) exp_out(K_BC, 255, "bc_255");
      if (i == 299) begin
        exp_out(K_BC, 255, "bc_sat_299");
        exp_out(K_MC, 0,   "mc_zero_sat_run");
      end
    end
    next_cyc();
    drive(3, 1, 0, 3, 0, 0);
    exp_out(K_BC, 255, "bc_hold");

    // Mispredict, then a 1 ns reset pulse mid-RECOVER between edges.
    next_cyc();
    drive(7, 1, 1, 7, 1, 0);
    exp_out(K_MP, 1, "pre_pulse_mispred");
    next_cyc();
    drive(7, 1, 0, 7, 0, 0);
    exp_out(K_REC, 1, "pre_pulse_rec");
    next_cyc();
    nreset = 1'b0;
    #1;
    nreset = 1'b1;
    exp_out(K_REC, 0, "pulse_abandon");
    exp_out(K_TB,  0, "pulse_bht");
    exp_out(K_BC,  0, "pulse_bc");
    exp_out(K_MC,  0, "pulse_mc");

    // One taken resolve per index: WNT -> WT makes every entry predict taken.
    for (int i = 0; i < 16; i++) begin
      next_cyc();
      drive((i + 15) % 16, 1, 1, i, 1, 1);
      if (i == 0) exp_out(K_REC, 0, "post_pulse_rec");
      if (i > 0) exp_out(K_TB, 1, $sformatf("wnt_reset_idx%0d", i - 1));
    end
    next_cyc();
    drive(15, 1, 0, 0, 0, 0);
    exp_out(K_TB, 1, "wnt_reset_idx15");
    exp_out(K_BC, 16, "bc_sixteen");

    repeat (2) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
